usb_acia_fifo: RTL and testbench
================================

// Module: usb_acia_fifo
// PURPOSE
//  FIFO-buffered, parametrised ACIA-compatible bridge between the 8-bit CPU bus and the MUACM USB CDC byte streams.
//  Adds independent RX/TX FIFOs, level readback, programmable IRQ thresholds and a sticky TX-overflow flag.
//  Keeps the legacy status/data register layout at addr 0/1, so existing ACIA polling drivers run unchanged.
//  Sits between the CPU address decoder and the muacm rx/tx valid/ready ports.
// PARAMETERS
//  RX_AW  4  log2 RX FIFO depth (depth = 2**RX_AW, RX_AW >= 1)
//  TX_AW  4  log2 TX FIFO depth (depth = 2**TX_AW, TX_AW >= 1)
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst_n    in   1  asynchronous active-low reset
//  cs       in   1  chip select
//  we       in   1  write enable (1 = write, 0 = read)
//  addr     in   2  register select: 0 status/ctrl, 1 data, 2 RX level/thr, 3 TX level/thr
//  din      in   8  bus write data
//  dout     out  8  registered bus read data
//  rx_data  in   8  byte from USB
//  rx_val   in   1  rx_data valid
//  rx_rdy   out  1  bridge accepts rx_data (= RX FIFO not full)
//  tx_data  out  8  byte to USB (FWFT head of TX FIFO, 8'h00 when empty)
//  tx_val   out  1  TX FIFO not empty
//  tx_rdy   in   1  USB accepts tx_data
//  irq      out  1  high-true interrupt request
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFOs empty, counts 0, ctrl=8'h00, thresholds=1 (RX) and 0 (TX), ovf=0.
//   Outputs: dout=0, rx_rdy=1, tx_val=0, tx_data=0, irq=0.
//  Counts are RX_AW+1 / TX_AW+1 bits wide. Pointers wrap modulo depth. Full means count == depth.
//  RX push: on rx_val & rx_rdy. rx_rdy comes from the registered count only, so a full FIFO stalls USB (no RX loss).
//  TX pop: on tx_val & tx_rdy. tx_data/tx_val come from the registered state only.
//  Bus reads (cs & ~we) update dout one cycle later; without a read, dout holds its value:
//   addr0: status {irq, ovf, tx_full, rx_count>=rx_thr, 0, 0, ~tx_full, ~rx_empty}
//   addr1: RX head. Pops in the same cycle. When empty: dout=0, no pop.
//   addr2: {0.., rx_count}, zero-extended.
//   addr3: {0.., tx_count}, zero-extended.
//  Bus writes (cs & we):
//   addr0: ctrl <= din. Fields: [7] rie, [6:5] tsc, [4:2] ignored, [1:0] cds.
//   addr1: push din to TX FIFO when not full. If full (evaluated pre-cycle), drop the byte and set ovf,
//    even if a USB pop occurs in the same cycle.
//   addr2: rx_thr <= din. 0 is treated as 1; values above depth saturate to depth.
//   addr3: tx_thr <= din. Values above depth saturate to depth.
//  Flush: while cds == 2'b11, both FIFOs are held empty, ovf=0, pushes and pops are ignored, rx_rdy=0, tx_val=0.
//   Ctrl and thresholds are kept. Normal operation resumes the cycle after cds != 2'b11.
//  Simultaneous push+pop on the same FIFO (not full, not empty): count unchanged, both bytes handled.
//  Pop on an empty FIFO or push on a full one never changes pointers.
//  ovf: sticky. Cleared only by reset or flush.
//  irq (combinational from registers):
//   (rie & rx_count>=rx_thr) | (tsc==2'b01 & tx_count<=tx_thr) | (rie & ovf)
//  Read/write with cs=0 has no effect. Reset mid-transfer discards all FIFO contents immediately.
// TESTING
//  Reset, then read addr0 -> dout=8'h03? No: RX empty, so 8'h02; rx_rdy=1, tx_val=0, tx_data=0, irq=0.
//  USB pushes 16 bytes 8'h10..8'h1F with rx_val held -> rx_rdy=0 after the 16th; addr2 reads 16;
//   16 addr1 reads return 8'h10..8'h1F in order; a 17th read returns 0.
//  Write 17 bytes with tx_rdy=0 -> tx_count=16, status bit6=1; write ctrl 8'h80 -> irq=1;
//   then tx_rdy=1 drains 16 bytes in 16 cycles in order, and tx_val drops.
//  rx_thr=4, rie=1: irq stays 0 for 3 RX bytes and rises the cycle the 4th is pushed; falls after one addr1 read.
//  tsc=01, tx_thr=2, 5 bytes queued -> irq=0 until tx_count reaches 2.
//   Ctrl write 8'h03 mid-drain -> tx_val=0 next cycle; counts 0; ovf=0.
//  Simultaneous USB RX push and addr1 pop at count 3 for 10 cycles -> count stays 3 and data stays in order;
//   rst_n pulse mid-stream -> all outputs go to reset values asynchronously.
```

Note: the first TESTING line should read: "Reset, then read addr0 -> dout=8'h02 (RX empty, TX not full); rx_rdy=1, tx_val=0, tx_data=0, irq=0."

Source files
------------

// File: rtl/usb_acia_fifo_if.sv
// Purpose: bundle of the CPU-bus and USB byte-stream signals of the ACIA FIFO bridge.
// Ports:
//   cs/we/addr/din/dout      CPU register bus (dout registered by the bridge)
//   rx_data/rx_val/rx_rdy    byte stream from USB into the RX FIFO
//   tx_data/tx_val/tx_rdy    byte stream from the TX FIFO to USB
//   irq                      interrupt request to the CPU
// Modports: slave = bridge side, master = CPU/USB side.
interface usb_acia_fifo_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rx_data;
  logic       rx_val;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_val;
  logic       tx_rdy;
  logic       irq;

  modport slave (
    input  cs, we, addr, din, rx_data, rx_val, tx_rdy,
    output dout, rx_rdy, tx_data, tx_val, irq
  );

  modport master (
    output cs, we, addr, din, rx_data, rx_val, tx_rdy,
    input  dout, rx_rdy, tx_data, tx_val, irq
  );
endinterface

// File: rtl/usb_acia_fifo.sv
// Purpose: FIFO-buffered ACIA-compatible bridge between an 8-bit CPU bus and USB CDC byte streams.
//   Legacy status at addr 0 and data at addr 1; RX/TX level and thresholds at addr 2/3.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    usb_acia_fifo_if.slave: CPU bus (cs/we/addr/din/dout), USB RX (rx_data/rx_val/rx_rdy),
//          USB TX (tx_data/tx_val/tx_rdy) and irq
// Parameters: RX_AW / TX_AW = log2 of the RX / TX FIFO depth.
module usb_acia_fifo #(
  parameter int RX_AW = 4,
  parameter int TX_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  usb_acia_fifo_if.slave   bus
);
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [RX_AW:0]   rx_cnt, rx_thr;
  logic [TX_AW:0]   tx_cnt, tx_thr;
  logic             rie;
  logic [1:0]       tsc, cds;
  logic             ovf;
  logic [7:0]       dout_q;

  // Threshold writes: RX threshold 0 acts as 1; both clamp to the FIFO depth.
  function automatic logic [RX_AW:0] sat_rx(input logic [7:0] v);
    if (v == 8'd0) return (RX_AW+1)'(1);
    if (int'(v) > RX_DEPTH) return RX_FULL;
    return (RX_AW+1)'(v);
  endfunction

  function automatic logic [TX_AW:0] sat_tx(input logic [7:0] v);
    if (int'(v) > TX_DEPTH) return TX_FULL;
    return (TX_AW+1)'(v);
  endfunction

  logic flush, rd, wr;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_wr, tx_push, tx_pop;
  logic rx_ge, tx_le, irq_c;
  logic [7:0] status;

  assign flush    = (cds == 2'b11);
  assign rd       = bus.cs & ~bus.we;
  assign wr       = bus.cs & bus.we;
  assign rx_full  = (rx_cnt == RX_FULL);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL);
  assign tx_empty = (tx_cnt == '0);

  // Handshakes depend only on registered state, so USB sees no combinational path from the CPU bus.
  assign rx_push = bus.rx_val & ~rx_full & ~flush;
  assign rx_pop  = rd & (bus.addr == 2'd1) & ~rx_empty & ~flush;
  assign tx_wr   = wr & (bus.addr == 2'd1) & ~flush;
  assign tx_push = tx_wr & ~tx_full;
  assign tx_pop  = ~tx_empty & ~flush & bus.tx_rdy;

  assign rx_ge  = (rx_cnt >= rx_thr);
  assign tx_le  = (tx_cnt <= tx_thr);
  assign irq_c  = (rie & rx_ge) | ((tsc == 2'b01) & tx_le) | (rie & ovf);
  assign status = {irq_c, ovf, tx_full, rx_ge, 2'b00, ~tx_full, ~rx_empty};

  assign bus.rx_rdy  = ~rx_full & ~flush;
  assign bus.tx_val  = ~tx_empty & ~flush;
  assign bus.tx_data = bus.tx_val ? tx_mem[tx_rp] : 8'h00;
  assign bus.irq     = irq_c;
  assign bus.dout    = dout_q;

  // FIFO storage carries no reset; emptiness is tracked by the counts.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
    if (tx_push) tx_mem[tx_wp] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_thr <= (RX_AW+1)'(1);
      tx_thr <= '0;
      rie    <= 1'b0;
      tsc    <= 2'b00;
      cds    <= 2'b00;
      ovf    <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      if (flush) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
        ovf    <= 1'b0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
        if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
        rx_cnt <= rx_cnt + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
        tx_cnt <= tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        // Fullness is judged before this cycle's USB pop, so a write racing a drain still drops.
        if (tx_wr && tx_full) ovf <= 1'b1;
      end

      if (wr) begin
        unique case (bus.addr)
          2'd0: begin
            rie <= bus.din[7];
            tsc <= bus.din[6:5];
            cds <= bus.din[1:0];
          end
          2'd2:    rx_thr <= sat_rx(bus.din);
          2'd3:    tx_thr <= sat_tx(bus.din);
          default: ;
        endcase
      end

      if (rd) begin
        unique case (bus.addr)
          2'd0: dout_q <= status;
          2'd1: dout_q <= rx_pop ? rx_mem[rx_rp] : 8'h00;
          2'd2: dout_q <= 8'(rx_cnt);
          2'd3: dout_q <= 8'(tx_cnt);
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_acia_fifo.sv
// Purpose: self-checking bench for usb_acia_fifo (depth 16/16) with a queue-based reference model.
// Ports: none (top-level bench).
module tb_usb_acia_fifo;
  localparam int RXD = 16;
  localparam int TXD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_acia_fifo_if bus();
  usb_acia_fifo #(.RX_AW(4), .TX_AW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] m_ctrl, m_dout;
  int         m_rxthr, m_txthr;
  bit         m_ovf;
  bit         g_txr;

  function automatic logic m_irq();
    return (m_ctrl[7] && rxq.size() >= m_rxthr) ||
           (m_ctrl[6:5] == 2'b01 && txq.size() <= m_txthr) ||
           (m_ctrl[7] && m_ovf);
  endfunction

  function automatic logic [7:0] m_status();
    return {m_irq(), m_ovf, (txq.size() == TXD), (rxq.size() >= m_rxthr),
            2'b00, (txq.size() != TXD), (rxq.size() != 0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_ctrl = 8'h00;
    m_dout = 8'h00;
    m_rxthr = 1;
    m_txthr = 0;
    m_ovf = 0;
  endtask

  // One bus/USB cycle: check registered outputs, advance the model, clock, check dout.
  task automatic cyc(input bit cs, input bit we, input logic [1:0] a, input logic [7:0] d,
                     input bit rv, input logic [7:0] rdat, input bit tr);
    bit flush, e_rdy, e_tv, rx_push, tx_pop, tx_full;
    logic [7:0] e_td;
    bus.cs = cs; bus.we = we; bus.addr = a; bus.din = d;
    bus.rx_val = rv; bus.rx_data = rdat; bus.tx_rdy = tr;
    flush = (m_ctrl[1:0] == 2'b11);
    e_rdy = !flush && rxq.size() < RXD;
    e_tv  = !flush && txq.size() != 0;
    e_td  = e_tv ? txq[0] : 8'h00;
    chk("rx_rdy", 32'(bus.rx_rdy), 32'(e_rdy));
    chk("tx_val", 32'(bus.tx_val), 32'(e_tv));
    chk("tx_data", 32'(bus.tx_data), 32'(e_td));
    chk("irq", 32'(bus.irq), 32'(m_irq()));
    rx_push = rv && e_rdy;
    tx_pop  = e_tv && tr;
    tx_full = (txq.size() == TXD);
    if (cs && !we) begin
      case (a)
        2'd0: m_dout = m_status();
        2'd1: begin
          if (!flush && rxq.size() != 0) m_dout = rxq.pop_front();
          else m_dout = 8'h00;
        end
        2'd2: m_dout = 8'(rxq.size());
        default: m_dout = 8'(txq.size());
      endcase
    end
    if (flush) begin
      rxq.delete();
      txq.delete();
      m_ovf = 0;
    end else begin
      if (tx_pop) void'(txq.pop_front());
      if (rx_push) rxq.push_back(rdat);
      if (cs && we && a == 2'd1) begin
        if (tx_full) m_ovf = 1;
        else txq.push_back(d);
      end
    end
    if (cs && we) begin
      case (a)
        2'd0: m_ctrl = d;
        2'd2: m_rxthr = (d == 0) ? 1 : ((d > RXD) ? RXD : int'(d));
        2'd3: m_txthr = (d > TXD) ? TXD : int'(d);
        default: ;
      endcase
    end
    @(posedge clk); #1;
    chk("dout", 32'(bus.dout), 32'(m_dout));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 2'd0, 8'h00, 0, 8'h00, g_txr);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cyc(1, 1, a, d, 0, 8'h00, g_txr);
  endtask
  task automatic rd(input logic [1:0] a);
    cyc(1, 0, a, 8'h00, 0, 8'h00, g_txr);
  endtask
  task automatic usb(input logic [7:0] d);
    cyc(0, 0, 2'd0, 8'h00, 1, d, g_txr);
  endtask

  // Reset is asserted between clock edges; outputs are checked before any edge arrives.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rx_rdy", 32'(bus.rx_rdy), 32'd1);
    chk("rst_tx_val", 32'(bus.tx_val), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0;
    bus.rx_val = 0; bus.rx_data = 0; bus.tx_rdy = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] sent [TXD];
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0;
    bus.rx_val = 0; bus.rx_data = 0; bus.tx_rdy = 0;
    g_txr = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset status: RX empty, TX not full.
    rd(2'd0);
    chk("status_reset", 32'(bus.dout), 32'h02);

    // Fill RX with rx_val held; the 17th offer must stall.
    for (int i = 0; i < 17; i++) usb(8'(8'h10 + i));
    chk("rx_full_stall", 32'(bus.rx_rdy), 32'd0);
    rd(2'd2);
    chk("rx_level16", 32'(bus.dout), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd(2'd1);
      chk("rx_order", 32'(bus.dout), 32'(8'h10 + i));
    end
    rd(2'd1);
    chk("rx_empty_read", 32'(bus.dout), 32'd0);

    // TX fill with overflow, irq from ovf, then drain in order.
    for (int i = 0; i < 17; i++) begin
      if (i < TXD) sent[i] = 8'($urandom);
      wr(2'd1, (i < TXD) ? sent[i] : 8'hEE);
    end
    rd(2'd3);
    chk("tx_level16", 32'(bus.dout), 32'd16);
    rd(2'd0);
    chk("status_ovf", 32'(bus.dout[6]), 32'd1);
    wr(2'd0, 8'h80);
    chk("irq_ovf", 32'(bus.irq), 32'd1);
    g_txr = 1;
    for (int i = 0; i < TXD; i++) begin
      chk("tx_drain", 32'(bus.tx_data), 32'(sent[i]));
      idle(1);
    end
    chk("tx_drained", 32'(bus.tx_val), 32'd0);
    g_txr = 0;

    // RX threshold interrupt.
    do_reset();
    wr(2'd2, 8'd4);
    wr(2'd0, 8'h80);
    for (int i = 0; i < 3; i++) begin
      usb(8'($urandom));
      chk("irq_below_thr", 32'(bus.irq), 32'd0);
    end
    usb(8'h44);
    chk("irq_at_thr", 32'(bus.irq), 32'd1);
    rd(2'd1);
    chk("irq_after_pop", 32'(bus.irq), 32'd0);

    // TX threshold interrupt, overflow, then flush mid-drain.
    do_reset();
    wr(2'd0, 8'h20);
    wr(2'd3, 8'd2);
    for (int i = 0; i < 17; i++) wr(2'd1, 8'($urandom));
    chk("tx_irq_off", 32'(bus.irq), 32'd0);
    g_txr = 1;
    idle(14);
    chk("tx_irq_on", 32'(bus.irq), 32'd1);
    wr(2'd0, 8'h03);
    chk("flush_tx_val", 32'(bus.tx_val), 32'd0);
    g_txr = 0;
    idle(2);
    wr(2'd0, 8'h00);
    rd(2'd3);
    chk("flush_tx_cnt", 32'(bus.dout), 32'd0);
    rd(2'd0);
    chk("flush_ovf", 32'(bus.dout[6]), 32'd0);

    // Simultaneous RX push and CPU pop at level 3.
    do_reset();
    for (int i = 0; i < 3; i++) usb(8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 2'd1, 8'h00, 1, 8'(8'hA3 + i), 0);
      chk("stream_order", 32'(bus.dout), 32'(8'hA0 + i));
    end
    rd(2'd2);
    chk("stream_level", 32'(bus.dout), 32'd3);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) cyc(1, 1, 2'd1, 8'($urandom), 1, 8'($urandom), 0);
    rd(2'd1);
    do_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      logic [1:0] a;
      bit cs, we, rv, tr;
      d  = 8'($urandom);
      a  = 2'($urandom);
      cs = ($urandom_range(0, 99) < 50);
      we = $urandom_range(0, 1) == 1;
      rv = ($urandom_range(0, 99) < ((i < 1500) ? 60 : 30));
      tr = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 60));
      if (cs && we && a == 2'd0 && d[1:0] == 2'b11 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      if (cs && we && a >= 2'd2 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 20));
      cyc(cs, we, a, d, rv, 8'($urandom), tr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
